lcd_timing_gen: RTL and testbench

Single-clock raster timing generator and pixel-alignment stage for the 800x480 RGB565 LCD panel. It feeds the panel pins directly. It issues per-pixel coordinate requests to an upstream pattern or framebuffer source with a fixed, parameterised return latency. It then registers the returned pixel alongside delayed DEN/HSYNC/VSYNC so that colour data and control always line up. It replaces the separate hsync/vsync counters, so no derived signal is ever used as a clock.

---
 rtl/lcd_timing_pkg.sv | 48 ++++
 rtl/lcd_delay_line.sv | 34 +++
 rtl/lcd_timing_gen.sv | 175 +++++++++++++++++
 tb/tb_lcd_timing_gen.sv | 422 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_timing_pkg.sv
// Shared timing constants, RGB565 field layout and FSM states for the LCD raster generator.
package lcd_timing_pkg;

  // Default 800x480 panel timing, in pixel clocks and lines.
  localparam int unsigned LCD_H_ACTIVE = 800;
  localparam int unsigned LCD_H_FP     = 210;
  localparam int unsigned LCD_H_SYNC   = 20;
  localparam int unsigned LCD_H_BP     = 26;
  localparam int unsigned LCD_H_TOTAL  = LCD_H_ACTIVE + LCD_H_FP + LCD_H_SYNC + LCD_H_BP;

  localparam int unsigned LCD_V_ACTIVE = 480;
  localparam int unsigned LCD_V_FP     = 22;
  localparam int unsigned LCD_V_SYNC   = 10;
  localparam int unsigned LCD_V_BP     = 13;
  localparam int unsigned LCD_V_TOTAL  = LCD_V_ACTIVE + LCD_V_FP + LCD_V_SYNC + LCD_V_BP;

  localparam int unsigned CNT_W   = 11;
  localparam int unsigned COORD_W = 10;
  localparam int unsigned PIX_W   = 16;

  // RGB565 field positions within the returned pixel.
  localparam int unsigned R_MSB = 15;
  localparam int unsigned R_LSB = 11;
  localparam int unsigned G_MSB = 10;
  localparam int unsigned G_LSB = 5;
  localparam int unsigned B_MSB = 4;
  localparam int unsigned B_LSB = 0;

  // Bit layout of the control flags carried through the delay line.
  localparam int unsigned FLAG_W   = 4;
  localparam int unsigned FLAG_DEN = 3;
  localparam int unsigned FLAG_HS  = 2;
  localparam int unsigned FLAG_VS  = 1;
  localparam int unsigned FLAG_FS  = 0;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } lcd_state_e;

  // Inclusive range test used for the sync windows.
  function automatic logic in_range(input logic [CNT_W-1:0] cnt,
                                    input logic [CNT_W-1:0] lo,
                                    input logic [CNT_W-1:0] hi);
    return (cnt >= lo) && (cnt <= hi);
  endfunction

endpackage

// File: rtl/lcd_delay_line.sv
// Fixed-depth shift register with async active-low clear; depth 0 is a plain wire.
module lcd_delay_line #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned DEPTH = 2
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  generate
    if (DEPTH == 0) begin : g_bypass
      logic w_unused;
      assign w_unused = i_clk ^ i_rst_n;
      assign o_q      = i_d;
    end else begin : g_pipe
      logic [WIDTH-1:0] r_stage [DEPTH];

      // Shift the vector one stage per clock; clear every stage on reset.
      always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
          for (int i = 0; i < DEPTH; i++) r_stage[i] <= '0;
        end else begin
          r_stage[0] <= i_d;
          for (int i = 1; i < DEPTH; i++) r_stage[i] <= r_stage[i-1];
        end
      end

      assign o_q = r_stage[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/lcd_timing_gen.sv
// Raster timing generator: counters, run FSM, pixel request stage and aligned panel outputs.
module lcd_timing_gen
  import lcd_timing_pkg::*;
#(
  parameter int unsigned H_ACTIVE = LCD_H_ACTIVE,
  parameter int unsigned H_FP     = LCD_H_FP,
  parameter int unsigned H_SYNC   = LCD_H_SYNC,
  parameter int unsigned H_BP     = LCD_H_BP,
  parameter int unsigned V_ACTIVE = LCD_V_ACTIVE,
  parameter int unsigned V_FP     = LCD_V_FP,
  parameter int unsigned V_SYNC   = LCD_V_SYNC,
  parameter int unsigned V_BP     = LCD_V_BP,
  parameter int unsigned PIPE_LAT = 2
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_en,
  output logic               o_req,
  output logic [COORD_W-1:0] o_req_x,
  output logic [COORD_W-1:0] o_req_y,
  input  logic [PIX_W-1:0]   i_pix,
  output logic               o_lcd_den,
  output logic               o_lcd_hsync_n,
  output logic               o_lcd_vsync_n,
  output logic [4:0]         o_lcd_r,
  output logic [5:0]         o_lcd_g,
  output logic [4:0]         o_lcd_b,
  output logic               o_frame_start
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CNT_W-1:0] H_ACT    = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] HS_FIRST = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] HS_LAST  = CNT_W'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [CNT_W-1:0] V_ACT    = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] VS_FIRST = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] VS_LAST  = CNT_W'(V_ACTIVE + V_FP + V_SYNC - 1);

  lcd_state_e         r_state;
  lcd_state_e         w_state_next;
  logic               w_run;
  logic [CNT_W-1:0]   r_h_cnt;
  logic [CNT_W-1:0]   r_v_cnt;
  logic               w_h_wrap;
  logic               w_v_wrap;
  logic               w_req_d;
  logic               w_hs_d;
  logic               w_vs_d;
  logic               w_fs_d;
  logic               r_req;
  logic [COORD_W-1:0] r_req_x;
  logic [COORD_W-1:0] r_req_y;
  logic [FLAG_W-1:0]  r_flags;
  logic [FLAG_W-1:0]  w_flags_dly;
  logic               r_den;
  logic               r_hsync_n;
  logic               r_vsync_n;
  logic               r_fs;
  logic [PIX_W-1:0]   r_rgb;

  assign w_h_wrap = (r_h_cnt == H_LAST);
  assign w_v_wrap = (r_v_cnt == V_LAST);

  // Next state and run qualifier. The IDLE->RUN cycle already counts as running so the
  // first request is registered on the same edge that samples i_en.
  always_comb begin
    w_state_next = r_state;
    w_run        = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (i_en) begin
          w_state_next = RUN;
          w_run        = 1'b1;
        end
      end
      RUN: begin
        w_run = 1'b1;
        // i_en only matters on the last pixel of a frame, so frames always complete.
        if (w_h_wrap && w_v_wrap && !i_en) w_state_next = IDLE;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= IDLE;
    else          r_state <= w_state_next;
  end

  // Raster counters: advance while running, otherwise parked at the origin.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_h_cnt <= '0;
      r_v_cnt <= '0;
    end else if (w_run) begin
      if (w_h_wrap) begin
        r_h_cnt <= '0;
        r_v_cnt <= w_v_wrap ? '0 : r_v_cnt + 1'b1;
      end else begin
        r_h_cnt <= r_h_cnt + 1'b1;
      end
    end else begin
      r_h_cnt <= '0;
      r_v_cnt <= '0;
    end
  end

  // Per-position decode feeding the request register.
  always_comb begin
    w_req_d = w_run && (r_h_cnt < H_ACT) && (r_v_cnt < V_ACT);
    w_hs_d  = w_run && in_range(r_h_cnt, HS_FIRST, HS_LAST);
    w_vs_d  = w_run && in_range(r_v_cnt, VS_FIRST, VS_LAST);
    w_fs_d  = w_run && (r_h_cnt == '0) && (r_v_cnt == '0);
  end

  // Request stage; coordinates hold their last value outside the active area.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_req   <= 1'b0;
      r_req_x <= '0;
      r_req_y <= '0;
      r_flags <= '0;
    end else begin
      r_req   <= w_req_d;
      r_flags <= {w_req_d, w_hs_d, w_vs_d, w_fs_d};
      if (w_req_d) begin
        r_req_x <= r_h_cnt[COORD_W-1:0];
        r_req_y <= r_v_cnt[COORD_W-1:0];
      end
    end
  end

  lcd_delay_line #(
    .WIDTH(FLAG_W),
    .DEPTH(PIPE_LAT)
  ) u_delay (
    .i_clk  (i_clk),
    .i_rst_n(i_rst_n),
    .i_d    (r_flags),
    .o_q    (w_flags_dly)
  );

  // Output stage: capture returned pixel together with its delayed control flags.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_den     <= 1'b0;
      r_hsync_n <= 1'b1;
      r_vsync_n <= 1'b1;
      r_fs      <= 1'b0;
      r_rgb     <= '0;
    end else begin
      r_den     <= w_flags_dly[FLAG_DEN];
      r_hsync_n <= ~w_flags_dly[FLAG_HS];
      r_vsync_n <= ~w_flags_dly[FLAG_VS];
      r_fs      <= w_flags_dly[FLAG_FS];
      r_rgb     <= w_flags_dly[FLAG_DEN] ? i_pix : '0;
    end
  end

  assign o_req         = r_req;
  assign o_req_x       = r_req_x;
  assign o_req_y       = r_req_y;
  assign o_lcd_den     = r_den;
  assign o_lcd_hsync_n = r_hsync_n;
  assign o_lcd_vsync_n = r_vsync_n;
  assign o_frame_start = r_fs;
  assign o_lcd_r       = r_rgb[R_MSB:R_LSB];
  assign o_lcd_g       = r_rgb[G_MSB:G_LSB];
  assign o_lcd_b       = r_rgb[B_MSB:B_LSB];

endmodule

// File: tb/tb_lcd_timing_gen.sv
// Bench for lcd_timing_gen: default-geometry instance (PIPE_LAT=2) plus two scaled-down
// geometries (PIPE_LAT=0 and 8) so whole frames fit in a short run.
module tb_lcd_timing_gen;

  typedef struct {
    int ha; int hfp; int hsw; int hbp;
    int va; int vfp; int vsw; int vbp;
    int lat;
  } geom_t;

  localparam int LATS [3] = '{2, 0, 8};
  localparam int BIG = 100;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en     [3];
  logic        req    [3];
  logic [9:0]  rx     [3];
  logic [9:0]  ry     [3];
  logic [15:0] pix    [3];
  logic        den    [3];
  logic        hs_n   [3];
  logic        vs_n   [3];
  logic        fs     [3];
  logic [4:0]  rr     [3];
  logic [5:0]  gg     [3];
  logic [4:0]  bb     [3];

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  lcd_timing_gen #(.PIPE_LAT(2)) u_dut_a (
    .i_clk(clk), .i_rst_n(rst_n), .i_en(en[0]), .o_req(req[0]), .o_req_x(rx[0]),
    .o_req_y(ry[0]), .i_pix(pix[0]), .o_lcd_den(den[0]), .o_lcd_hsync_n(hs_n[0]),
    .o_lcd_vsync_n(vs_n[0]), .o_lcd_r(rr[0]), .o_lcd_g(gg[0]), .o_lcd_b(bb[0]),
    .o_frame_start(fs[0])
  );

  lcd_timing_gen #(
    .H_ACTIVE(16), .H_FP(5), .H_SYNC(3), .H_BP(4),
    .V_ACTIVE(10), .V_FP(3), .V_SYNC(2), .V_BP(2), .PIPE_LAT(0)
  ) u_dut_b (
    .i_clk(clk), .i_rst_n(rst_n), .i_en(en[1]), .o_req(req[1]), .o_req_x(rx[1]),
    .o_req_y(ry[1]), .i_pix(pix[1]), .o_lcd_den(den[1]), .o_lcd_hsync_n(hs_n[1]),
    .o_lcd_vsync_n(vs_n[1]), .o_lcd_r(rr[1]), .o_lcd_g(gg[1]), .o_lcd_b(bb[1]),
    .o_frame_start(fs[1])
  );

  lcd_timing_gen #(
    .H_ACTIVE(16), .H_FP(5), .H_SYNC(3), .H_BP(4),
    .V_ACTIVE(10), .V_FP(3), .V_SYNC(2), .V_BP(2), .PIPE_LAT(8)
  ) u_dut_c (
    .i_clk(clk), .i_rst_n(rst_n), .i_en(en[2]), .o_req(req[2]), .o_req_x(rx[2]),
    .o_req_y(ry[2]), .i_pix(pix[2]), .o_lcd_den(den[2]), .o_lcd_hsync_n(hs_n[2]),
    .o_lcd_vsync_n(vs_n[2]), .o_lcd_r(rr[2]), .o_lcd_g(gg[2]), .o_lcd_b(bb[2]),
    .o_frame_start(fs[2])
  );

  function automatic geom_t geom(input int i);
    geom_t g;
    if (i == 0) g = '{800, 210, 20, 26, 480, 22, 10, 13, 2};
    else        g = '{16, 5, 3, 4, 10, 3, 2, 2, LATS[i]};
    return g;
  endfunction

  function automatic logic [15:0] echo(input logic [9:0] x, input logic [9:0] y);
    return {x[4:0], y[5:0], x[4:0]};
  endfunction

  // Upstream source: returns the echo of each request exactly LAT cycles later; random
  // garbage in every other cycle.
  logic [9:0]  hx    [3][9];
  logic [9:0]  hy    [3][9];
  logic        hreq  [3][9];
  logic [15:0] noise [3];

  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      hx[i][0]   <= rx[i];
      hy[i][0]   <= ry[i];
      hreq[i][0] <= req[i];
      for (int k = 1; k < 9; k++) begin
        hx[i][k]   <= hx[i][k-1];
        hy[i][k]   <= hy[i][k-1];
        hreq[i][k] <= hreq[i][k-1];
      end
      noise[i] <= 16'($urandom);
    end
  end

  always_comb begin
    for (int i = 0; i < 3; i++) begin
      pix[i] = noise[i];
      if (LATS[i] == 0) begin
        if (req[i]) pix[i] = echo(rx[i], ry[i]);
      end else begin
        if (hreq[i][LATS[i]-1]) pix[i] = echo(hx[i][LATS[i]-1], hy[i][LATS[i]-1]);
      end
    end
  end

  // Reference: n counts cycles after the edge that sampled i_en high. The request seen in
  // cycle n is raster position n; the panel outputs show position n-(LAT+1). Positions at or
  // beyond `frames` whole frames are idle.
  function automatic logic [19:0] ref_out(input int i, input int n, input int frames);
    geom_t gm;
    int    ht, vt, p, h, v;
    logic  d, hsa, vsa;
    gm = geom(i);
    ht = gm.ha + gm.hfp + gm.hsw + gm.hbp;
    vt = gm.va + gm.vfp + gm.vsw + gm.vbp;
    p  = n - (gm.lat + 1);
    if (p < 0 || p >= frames * ht * vt) return {1'b0, 1'b1, 1'b1, 1'b0, 16'h0000};
    h   = p % ht;
    v   = (p / ht) % vt;
    d   = (h < gm.ha) && (v < gm.va);
    hsa = (h >= gm.ha + gm.hfp) && (h < gm.ha + gm.hfp + gm.hsw);
    vsa = (v >= gm.va + gm.vfp) && (v < gm.va + gm.vfp + gm.vsw);
    return {d, ~hsa, ~vsa, (h == 0) && (v == 0), d ? echo(10'(h), 10'(v)) : 16'h0000};
  endfunction

  function automatic logic [20:0] ref_req(input int i, input int n, input int frames);
    geom_t gm;
    int    ht, vt, h, v;
    gm = geom(i);
    ht = gm.ha + gm.hfp + gm.hsw + gm.hbp;
    vt = gm.va + gm.vfp + gm.vsw + gm.vbp;
    if (n >= frames * ht * vt) return {1'b0, 10'(gm.ha - 1), 10'(gm.va - 1)};
    h = n % ht;
    v = (n / ht) % vt;
    if (h < gm.ha && v < gm.va) return {1'b1, 10'(h), 10'(v)};
    if (v < gm.va)              return {1'b0, 10'(gm.ha - 1), 10'(v)};
    return {1'b0, 10'(gm.ha - 1), 10'(gm.va - 1)};
  endfunction

  function automatic logic [19:0] obs_out(input int i);
    return {den[i], hs_n[i], vs_n[i], fs[i], rr[i], gg[i], bb[i]};
  endfunction

  function automatic logic [20:0] obs_req(input int i);
    return {req[i], rx[i], ry[i]};
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) en[i] = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) en[i] = 1'b0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (obs_out(i) !== {1'b0, 1'b1, 1'b1, 1'b0, 16'h0000}) begin
        n_err++;
        $display("FAIL reset_out dut=%0d got=%h exp=%h", i, obs_out(i), 20'h60000);
      end
      n_cmp++;
      if (obs_req(i) !== 21'h0) begin
        n_err++;
        $display("FAIL reset_req dut=%0d got=%h exp=0", i, obs_req(i));
      end
    end
    rst_n = 1'b1;
    // Released but not enabled: stays idle.
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        n_cmp++;
        if ({obs_req(i), obs_out(i)} !== {21'h0, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0000}) begin
          n_err++;
          $display("FAIL idle_hold dut=%0d c=%0d got=%h/%h", i, c, obs_req(i), obs_out(i));
        end
      end
    end
  endtask

  task automatic test_first_request();
    int first_req, first_den, first_fs;
    first_req = -1; first_den = -1; first_fs = -1;
    do_reset();
    en[0] = 1'b1;
    for (int n = 0; n < 3 * 1056 + 10; n++) begin
      @(negedge clk);
      if (req[0] && first_req < 0) first_req = n;
      if (den[0] && first_den < 0) first_den = n;
      if (fs[0] && first_fs < 0)   first_fs = n;
      n_cmp++;
      if (obs_req(0) !== ref_req(0, n, BIG)) begin
        n_err++;
        $display("FAIL a_req n=%0d got=%h exp=%h", n, obs_req(0), ref_req(0, n, BIG));
      end
      n_cmp++;
      if (obs_out(0) !== ref_out(0, n, BIG)) begin
        n_err++;
        $display("FAIL a_out n=%0d got=%h exp=%h", n, obs_out(0), ref_out(0, n, BIG));
      end
    end
    n_cmp++;
    if (first_req !== 0) begin
      n_err++; $display("FAIL first_req got=%0d exp=0", first_req);
    end
    n_cmp++;
    if (first_den !== 3) begin
      n_err++; $display("FAIL first_den got=%0d exp=3", first_den);
    end
    n_cmp++;
    if (first_fs !== 3) begin
      n_err++; $display("FAIL first_fs got=%0d exp=3", first_fs);
    end
  endtask

  task automatic test_line_timing();
    int den_r0, den_r1, den_len, hs_start, hs_len;
    logic prev_den;
    den_r0 = -1; den_r1 = -1; den_len = 0; hs_start = -1; hs_len = 0; prev_den = 1'b0;
    do_reset();
    en[0] = 1'b1;
    for (int n = 0; n < 2300; n++) begin
      @(negedge clk);
      if (den[0] && !prev_den) begin
        if (den_r0 < 0)      den_r0 = n;
        else if (den_r1 < 0) den_r1 = n;
      end
      if (den[0] && den_r1 < 0) den_len++;
      if (!hs_n[0] && den_r1 < 0) begin
        if (hs_start < 0) hs_start = n;
        hs_len++;
      end
      prev_den = den[0];
    end
    n_cmp++;
    if (hs_start - den_r0 !== 1010) begin
      n_err++; $display("FAIL hsync_offset got=%0d exp=1010", hs_start - den_r0);
    end
    n_cmp++;
    if (hs_len !== 20) begin
      n_err++; $display("FAIL hsync_width got=%0d exp=20", hs_len);
    end
    n_cmp++;
    if (den_r1 - den_r0 !== 1056) begin
      n_err++; $display("FAIL line_period got=%0d exp=1056", den_r1 - den_r0);
    end
    n_cmp++;
    if (den_len !== 800) begin
      n_err++; $display("FAIL den_run got=%0d exp=800", den_len);
    end
  endtask

  task automatic test_frame_small();
    int den_cnt, vs_cnt, fs0, fs1, vs0, first_req, first_den;
    logic [15:0] corner;
    den_cnt = 0; vs_cnt = 0; fs0 = -1; fs1 = -1; vs0 = -1; first_req = -1; first_den = -1;
    corner = 16'hxxxx;
    do_reset();
    en[1] = 1'b1;
    for (int n = 0; n < 2 * 476 + 5; n++) begin
      @(negedge clk);
      if (req[1] && first_req < 0) first_req = n;
      if (den[1] && first_den < 0) first_den = n;
      if (fs[1]) begin
        if (fs0 < 0)      fs0 = n;
        else if (fs1 < 0) fs1 = n;
      end
      if (n >= 1 && n < 1 + 476) begin
        if (den[1])   den_cnt++;
        if (!vs_n[1]) begin
          vs_cnt++;
          if (vs0 < 0) vs0 = n;
        end
      end
      // Last visible pixel (15,9) sits at position 9*28+15 = 267.
      if (n == 268) corner = {rr[1], gg[1], bb[1]};
      n_cmp++;
      if ({obs_req(1), obs_out(1)} !== {ref_req(1, n, BIG), ref_out(1, n, BIG)}) begin
        n_err++;
        $display("FAIL b_stream n=%0d got=%h/%h exp=%h/%h", n, obs_req(1), obs_out(1),
                 ref_req(1, n, BIG), ref_out(1, n, BIG));
      end
    end
    n_cmp++;
    if (den_cnt !== 160) begin
      n_err++; $display("FAIL den_per_frame got=%0d exp=160", den_cnt);
    end
    n_cmp++;
    if (fs1 - fs0 !== 476) begin
      n_err++; $display("FAIL frame_period got=%0d exp=476", fs1 - fs0);
    end
    n_cmp++;
    if (vs0 - fs0 !== 364) begin
      n_err++; $display("FAIL vsync_offset got=%0d exp=364", vs0 - fs0);
    end
    n_cmp++;
    if (vs_cnt !== 56) begin
      n_err++; $display("FAIL vsync_width got=%0d exp=56", vs_cnt);
    end
    n_cmp++;
    if (first_den - first_req !== 1) begin
      n_err++; $display("FAIL lat0_align got=%0d exp=1", first_den - first_req);
    end
    n_cmp++;
    if (corner !== 16'h792F) begin
      n_err++; $display("FAIL corner_pixel got=%h exp=792f", corner);
    end
  endtask

  task automatic test_en_drop();
    int n_drop, g_on, g_off, gap;
    n_drop = $urandom_range(28, 380);
    g_on   = n_drop + $urandom_range(5, 30);
    g_off  = g_on + $urandom_range(1, 10);
    gap    = $urandom_range(1, 20);
    do_reset();
    en[1] = 1'b1;
    for (int n = 0; n < 476 + 20; n++) begin
      @(negedge clk);
      n_cmp++;
      if ({obs_req(1), obs_out(1)} !== {ref_req(1, n, 1), ref_out(1, n, 1)}) begin
        n_err++;
        $display("FAIL drop_stream n=%0d drop=%0d got=%h/%h exp=%h/%h", n, n_drop, obs_req(1),
                 obs_out(1), ref_req(1, n, 1), ref_out(1, n, 1));
      end
      if (n == n_drop) en[1] = 1'b0;
      if (n == g_on)   en[1] = 1'b1;
      if (n == g_off)  en[1] = 1'b0;
    end
    repeat (gap) @(negedge clk);
    n_cmp++;
    if ({den[1], hs_n[1], vs_n[1], rr[1], gg[1], bb[1], req[1]} !== {3'b011, 16'h0, 1'b0}) begin
      n_err++;
      $display("FAIL stopped_idle got=%h exp=60000", obs_out(1));
    end
    en[1] = 1'b1;
    for (int n = 0; n < 60; n++) begin
      @(negedge clk);
      n_cmp++;
      if ({obs_req(1), obs_out(1)} !== {ref_req(1, n, BIG), ref_out(1, n, BIG)}) begin
        n_err++;
        $display("FAIL restart n=%0d got=%h/%h exp=%h/%h", n, obs_req(1), obs_out(1),
                 ref_req(1, n, BIG), ref_out(1, n, BIG));
      end
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    en[0] = 1'b1;
    for (int n = 0; n <= 400; n++) begin
      @(negedge clk);
      n_cmp++;
      if ({obs_req(0), obs_out(0)} !== {ref_req(0, n, BIG), ref_out(0, n, BIG)}) begin
        n_err++;
        $display("FAIL pre_reset n=%0d got=%h/%h", n, obs_req(0), obs_out(0));
      end
    end
    // Mid-cycle, away from any clock edge.
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({obs_req(0), obs_out(0)} !== {21'h0, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0000}) begin
      n_err++;
      $display("FAIL async_reset got=%h/%h exp=000000/60000", obs_req(0), obs_out(0));
    end
    en[0] = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    en[0] = 1'b1;
    for (int n = 0; n < 1200; n++) begin
      @(negedge clk);
      n_cmp++;
      if ({obs_req(0), obs_out(0)} !== {ref_req(0, n, BIG), ref_out(0, n, BIG)}) begin
        n_err++;
        $display("FAIL post_reset n=%0d got=%h/%h exp=%h/%h", n, obs_req(0), obs_out(0),
                 ref_req(0, n, BIG), ref_out(0, n, BIG));
      end
    end
  endtask

  task automatic test_latency_8();
    int first_req, first_den;
    first_req = -1; first_den = -1;
    do_reset();
    en[2] = 1'b1;
    for (int n = 0; n < 476 + 30; n++) begin
      @(negedge clk);
      if (req[2] && first_req < 0) first_req = n;
      if (den[2] && first_den < 0) first_den = n;
      n_cmp++;
      if ({obs_req(2), obs_out(2)} !== {ref_req(2, n, BIG), ref_out(2, n, BIG)}) begin
        n_err++;
        $display("FAIL c_stream n=%0d got=%h/%h exp=%h/%h", n, obs_req(2), obs_out(2),
                 ref_req(2, n, BIG), ref_out(2, n, BIG));
      end
    end
    n_cmp++;
    if (first_den - first_req !== 9) begin
      n_err++; $display("FAIL lat8_align got=%0d exp=9", first_den - first_req);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) en[i] = 1'b0;
    test_reset();
    test_first_request();
    test_line_timing();
    test_frame_small();
    test_en_drop();
    test_async_reset();
    test_latency_8();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
